// File: rtl/weight_tile_scheduler.sv
// Tile sequencer for the weight-BRAM wavefront address counter: splits a job into
// tiles, handshakes with the PE array, launches one counter scan per tile, with abort and watchdog.
module weight_tile_scheduler #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned TILE_W     = 6,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
  input  logic [TILE_W-1:0]     cfg_tiles,
  input  logic                  pe_ready,
  input  logic                  abort,
  output logic                  wc_start,
  output logic [ADDR_WIDTH-1:0] wc_addr_start,
  output logic [ADDR_WIDTH-1:0] wc_addr_end,
  input  logic                  wc_done,
  output logic                  busy,
  output logic [TILE_W-1:0]     tile_idx,
  output logic                  tile_done,
  output logic                  all_done,
  output logic                  aborted,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = ADDR_WIDTH + TILE_W + 1;
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] ADDR_SPAN = SW'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, WAIT_PE, LAUNCH, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [TILE_W-1:0]     tiles_q, tiles_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  cfg_ready_d, busy_d, wc_start_d;
  logic [ADDR_WIDTH-1:0] wc_addr_start_d, wc_addr_end_d;
  logic [TILE_W-1:0]     tile_idx_d;
  logic                  tile_done_d, all_done_d, aborted_d, err_d;
  logic [1:0]            err_code_d;

  logic [SW-1:0]         cfg_sum;
  logic                  cfg_bad, last_tile, timed_out;

  always_comb begin
    cfg_sum   = SW'(cfg_base) + SW'(cfg_tiles) * SW'(cfg_len);
    cfg_bad   = (cfg_len == '0) || (cfg_tiles == '0) || (cfg_sum > ADDR_SPAN);
    last_tile = (tile_idx == tiles_q - TILE_W'(1));
    timed_out = (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    tiles_d         = tiles_q;
    cnt_d           = cnt_q;
    wc_start_d      = 1'b0;
    wc_addr_start_d = wc_addr_start;
    wc_addr_end_d   = wc_addr_end;
    tile_idx_d      = tile_idx;
    tile_done_d     = 1'b0;
    all_done_d      = 1'b0;
    aborted_d       = 1'b0;
    err_d           = 1'b0;
    err_code_d      = err_code;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else begin
            len_d           = cfg_len;
            tiles_d         = cfg_tiles;
            tile_idx_d      = '0;
            wc_addr_start_d = cfg_base;
            wc_addr_end_d   = cfg_base + cfg_len - ADDR_WIDTH'(1);
            err_code_d      = 2'b00;
            state_d         = WAIT_PE;
          end
        end
      end
      WAIT_PE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (pe_ready) begin
          wc_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        // The start pulse is already out, so an abort here must still wait for wc_done.
        cnt_d   = '0;
        state_d = abort ? DRAIN : RUN;
      end
      RUN: begin
        if (wc_done) begin
          tile_done_d = 1'b1;
          if (last_tile) begin
            all_done_d = 1'b1;
            state_d    = IDLE;
          end else if (abort) begin
            aborted_d = 1'b1;
            state_d   = IDLE;
          end else begin
            tile_idx_d      = tile_idx + TILE_W'(1);
            wc_addr_start_d = wc_addr_start + len_q;
            wc_addr_end_d   = wc_addr_end + len_q;
            state_d         = WAIT_PE;
          end
        end else if (timed_out) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (abort) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wc_done) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (timed_out) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cfg_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      tiles_q       <= '0;
      cnt_q         <= '0;
      cfg_ready     <= 1'b1;
      busy          <= 1'b0;
      wc_start      <= 1'b0;
      wc_addr_start <= '0;
      wc_addr_end   <= '0;
      tile_idx      <= '0;
      tile_done     <= 1'b0;
      all_done      <= 1'b0;
      aborted       <= 1'b0;
      err           <= 1'b0;
      err_code      <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      tiles_q       <= tiles_d;
      cnt_q         <= cnt_d;
      cfg_ready     <= cfg_ready_d;
      busy          <= busy_d;
      wc_start      <= wc_start_d;
      wc_addr_start <= wc_addr_start_d;
      wc_addr_end   <= wc_addr_end_d;
      tile_idx      <= tile_idx_d;
      tile_done     <= tile_done_d;
      all_done      <= all_done_d;
      aborted       <= aborted_d;
      err           <= err_d;
      err_code      <= err_code_d;
    end
  end

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Scoreboard bench for weight_tile_scheduler: the driver emulates the address counter and PE array
// and queues expected pulses/levels per cycle; a negedge monitor pops and compares them.
module tb_weight_tile_scheduler;

  localparam int AW = 9;
  localparam int TW = 6;
  localparam int TO = 15;

  localparam int K_START = 0;
  localparam int K_TDONE = 1;
  localparam int K_ADONE = 2;
  localparam int K_ABORT = 3;
  localparam int K_ERR   = 4;

  localparam int L_RDY  = 0;
  localparam int L_BUSY = 1;
  localparam int L_ERRC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_len = '0;
  logic [TW-1:0] cfg_tiles = '0;
  logic          pe_ready = 1'b0;
  logic          abort = 1'b0;
  logic          wc_done = 1'b0;
  logic          cfg_ready, wc_start, busy, tile_done, all_done, aborted, err;
  logic [AW-1:0] wc_addr_start, wc_addr_end;
  logic [TW-1:0] tile_idx;
  logic [1:0]    err_code;

  weight_tile_scheduler #(.ADDR_WIDTH(AW), .TILE_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_tiles(cfg_tiles),
    .pe_ready(pe_ready), .abort(abort), .wc_start(wc_start),
    .wc_addr_start(wc_addr_start), .wc_addr_end(wc_addr_end), .wc_done(wc_done),
    .busy(busy), .tile_idx(tile_idx), .tile_done(tile_done), .all_done(all_done),
    .aborted(aborted), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int cyc; int a; int b; int c; } ev_t;
  typedef struct { int cyc; int sig; int exp; } lv_t;
  ev_t eq[$];
  lv_t lq[$];

  int errors = 0;
  int checks = 0;
  bit fin = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_START: return "wc_start";
      K_TDONE: return "tile_done";
      K_ADONE: return "all_done";
      K_ABORT: return "aborted";
      default: return "err";
    endcase
  endfunction

  function automatic string lname(input int s);
    case (s)
      L_RDY:   return "cfg_ready";
      L_BUSY:  return "busy";
      default: return "err_code";
    endcase
  endfunction

  function automatic int lvl_val(input int s);
    case (s)
      L_RDY:   return int'(cfg_ready);
      L_BUSY:  return int'(busy);
      default: return int'(err_code);
    endcase
  endfunction

  task automatic see(input int kind, input int a, input int b, input int c);
    ev_t e;
    checks++;
    if (eq.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected pulse at cycle %0d (actual a=%0h b=%0h c=%0d, required no pulse)",
               kname(kind), cyc, a, b, c);
    end else begin
      e = eq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b || e.c != c) begin
        errors++;
        $display("FAIL %s: actual %s cyc=%0d a=%0h b=%0h c=%0d, required %s cyc=%0d a=%0h b=%0h c=%0d",
                 kname(e.kind), kname(kind), cyc, a, b, c, kname(e.kind), e.cyc, e.a, e.b, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    lv_t l;
    int  act;
    if (wc_start === 1'b1) see(K_START, int'(wc_addr_start), int'(wc_addr_end), int'(tile_idx));
    if (tile_done === 1'b1) see(K_TDONE, 0, 0, 0);
    if (all_done === 1'b1)  see(K_ADONE, 0, 0, 0);
    if (aborted === 1'b1)   see(K_ABORT, 0, 0, 0);
    if (err === 1'b1)       see(K_ERR, int'(err_code), 0, 0);
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      l = lq.pop_front();
      act = lvl_val(l.sig);
      checks++;
      if (l.cyc != cyc || act != l.exp) begin
        errors++;
        $display("FAIL %s@%0d: actual %0d (sampled cycle %0d), required %0d", lname(l.sig), l.cyc, act, cyc, l.exp);
      end
    end
    if (fin) begin
      checks++;
      if (eq.size() != 0 || lq.size() != 0) begin
        errors++;
        $display("FAIL leftover: actual %0d pulses and %0d levels never seen, required 0", eq.size(), lq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_ev(input int kind, input int t, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind; e.cyc = t; e.a = a; e.b = b; e.c = c;
    eq.push_back(e);
  endtask

  task automatic push_lvl(input int t, input int sig, input int exp);
    lv_t l;
    l.cyc = t; l.sig = sig; l.exp = exp;
    lq.push_back(l);
  endtask

  task automatic send_cfg(input int base, input int len, input int tiles);
    cfg_valid = 1'b1;
    cfg_base  = AW'(base);
    cfg_len   = AW'(len);
    cfg_tiles = TW'(tiles);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run_tile(input int idx, input int a0, input int a1, input int s, input int lat,
                          input bit last, input int stall, input bit ab, output int sn);
    push_ev(K_START, s, a0, a1, idx);
    wait_until(s + lat);
    wc_done = 1'b1;
    if (ab) abort = 1'b1;
    push_ev(K_TDONE, s + lat + 1, 0, 0, 0);
    if (last) begin
      push_ev(K_ADONE, s + lat + 1, 0, 0, 0);
      push_lvl(s + lat + 1, L_RDY, 1);
    end
    if (stall > 0) pe_ready = 1'b0;
    tick();
    wc_done = 1'b0;
    abort   = 1'b0;
    if (stall > 0) begin
      wait_until(s + lat + stall);
      pe_ready = 1'b1;
      sn = s + lat + stall + 1;
    end else begin
      sn = s + lat + 2;
    end
  endtask

  task automatic run_job(input int base, input int len, input int tiles, input int lat,
                         input int stall0, input bit abort_last);
    int s;
    int sn;
    pe_ready = 1'b1;
    push_lvl(cyc + 1, L_BUSY, 1);
    push_lvl(cyc + 1, L_ERRC, 0);
    send_cfg(base, len, tiles);
    s = cyc + 1;
    for (int i = 0; i < tiles; i++) begin
      run_tile(i, base + i * len, base + (i + 1) * len - 1, s, lat, i == tiles - 1,
               (i == 0) ? stall0 : 0, abort_last && (i == tiles - 1), sn);
      s = sn;
    end
  endtask

  task automatic bad_cfg(input int base, input int len, input int tiles);
    push_ev(K_ERR, cyc + 1, 1, 0, 0);
    push_lvl(cyc + 1, L_RDY, 1);
    push_lvl(cyc + 1, L_BUSY, 0);
    push_lvl(cyc + 1, L_ERRC, 1);
    send_cfg(base, len, tiles);
    repeat (2) tick();
  endtask

  initial begin
    int c;
    int s;
    push_lvl(3, L_RDY, 1);
    push_lvl(3, L_BUSY, 0);
    push_lvl(3, L_ERRC, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Nominal: starts (010,013) (014,017) (018,01B), idx 0,1,2
    run_job(32'h010, 4, 3, 4, 0, 1'b0);
    repeat (2) tick();

    bad_cfg(32'h010, 0, 2);
    bad_cfg(32'h010, 4, 0);
    bad_cfg(32'h1F0, 8, 3);

    // Exact fit: end address 1FF
    run_job(32'h1F8, 8, 1, 3, 0, 1'b0);
    repeat (2) tick();

    // PE backpressure after tile 0
    run_job(32'h040, 2, 2, 3, 21, 1'b0);
    repeat (2) tick();

    // Abort in WAIT_PE
    pe_ready = 1'b0;
    c = cyc;
    push_lvl(c + 1, L_BUSY, 1);
    send_cfg(32'h030, 4, 2);
    abort = 1'b1;
    push_ev(K_ABORT, c + 2, 0, 0, 0);
    push_lvl(c + 2, L_BUSY, 0);
    tick();
    abort = 1'b0;
    pe_ready = 1'b1;
    repeat (4) tick();

    // Abort in RUN, wc_done 10 cycles later
    c = cyc;
    send_cfg(32'h020, 3, 2);
    s = c + 2;
    push_ev(K_START, s, 32'h020, 32'h022, 0);
    wait_until(s + 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    push_lvl(s + 10, L_BUSY, 1);
    wait_until(s + 12);
    wc_done = 1'b1;
    push_ev(K_ABORT, s + 13, 0, 0, 0);
    push_lvl(s + 13, L_RDY, 1);
    tick();
    wc_done = 1'b0;
    repeat (3) tick();

    // Abort coinciding with last wc_done: completion wins
    run_job(32'h000, 1, 2, 2, 0, 1'b1);

    // Back-to-back accept on the all_done cycle, then timeout
    c = cyc;
    push_lvl(c + 1, L_BUSY, 1);
    send_cfg(32'h100, 4, 1);
    s = c + 2;
    push_ev(K_START, s, 32'h100, 32'h103, 0);
    push_ev(K_ERR, s + 16, 2, 0, 0);
    push_lvl(s + 16, L_RDY, 1);
    push_lvl(s + 16, L_BUSY, 0);
    push_lvl(s + 16, L_ERRC, 2);
    wait_until(s + 20);
    wc_done = 1'b1;
    tick();
    wc_done = 1'b0;
    repeat (3) tick();
    push_lvl(cyc + 1, L_ERRC, 2);
    push_lvl(cyc + 1, L_RDY, 1);
    repeat (2) tick();
    fin = 1'b1;
  end

endmodule
